id_ex_reg: RTL

ID_EX_REG -- requirements
Module: id_ex_reg

---
 rtl/id_ex_reg.sv | 103 ++++++++++
 1 files changed

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register: flush > stall > load, with bubbles on invalid ID.
// Define ID_EX_STATS_EN to add the saturating bubble_count output.
module id_ex_reg #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [8:0]        id_ctrl,
  input  logic [DATA_W-1:0] id_pc4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [4:0]        id_rs,
  input  logic [4:0]        id_rt,
  input  logic [4:0]        id_rd,
  output logic              ex_valid,
  output logic [8:0]        ex_ctrl,
  output logic [1:0]        ex_alu_op,
  output logic [5:0]        ex_funct,
  output logic [DATA_W-1:0] ex_pc4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [4:0]        ex_rs,
  output logic [4:0]        ex_rt,
  output logic [4:0]        ex_rd
`ifdef ID_EX_STATS_EN
  ,
  output logic [CNT_W-1:0]  bubble_count
`endif
);

  logic              w_bubble;
  logic              w_load;
  logic              r_valid;
  logic [8:0]        r_ctrl;
  logic [DATA_W-1:0] r_pc4;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [4:0]        r_rs;
  logic [4:0]        r_rt;
  logic [4:0]        r_rd;

  // flush wins over stall; an invalid ID slot on a free edge is also a bubble
  assign w_bubble = flush | (~stall & ~id_valid);
  assign w_load   = ~flush & ~stall & id_valid;

  always_ff @(posedge clk or posedge reset) begin
    if (reset || (w_bubble && !reset)) begin
      r_valid   <= 1'b0;
      r_ctrl    <= '0;
      r_pc4     <= '0;
      r_rs_data <= '0;
      r_rt_data <= '0;
      r_imm     <= '0;
      r_rs      <= '0;
      r_rt      <= '0;
      r_rd      <= '0;
    end else if (w_load) begin
      r_valid   <= 1'b1;
      r_ctrl    <= id_ctrl;
      r_pc4     <= id_pc4;
      r_rs_data <= id_rs_data;
      r_rt_data <= id_rt_data;
      r_imm     <= id_imm;
      r_rs      <= id_rs;
      r_rt      <= id_rt;
      r_rd      <= id_rd;
    end
  end

  assign ex_valid   = r_valid;
  assign ex_ctrl    = r_ctrl;
  assign ex_alu_op  = r_ctrl[8:7];
  assign ex_funct   = r_imm[5:0];
  assign ex_pc4     = r_pc4;
  assign ex_rs_data = r_rs_data;
  assign ex_rt_data = r_rt_data;
  assign ex_imm     = r_imm;
  assign ex_rs      = r_rs;
  assign ex_rt      = r_rt;
  assign ex_rd      = r_rd;

`ifdef ID_EX_STATS_EN
  logic [CNT_W-1:0] r_bubble_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bubble_cnt <= '0;
    end else if (w_bubble && (r_bubble_cnt != '1)) begin
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
    end
  end

  assign bubble_count = r_bubble_cnt;
`endif

endmodule
